// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - MSB-first serial operand framer with IDLE/SHIFT/GAP sequencing
// Build option SERIAL_OPERAND_FIFO_EN: FIFO_DEPTH-entry pair FIFO; otherwise a single holding register.
module serial_operand_feeder #(
  parameter int WIDTH      = 2,
  parameter int GAP        = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_en,
  output logic             ser_a,
  output logic             ser_b,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int OW      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [OW-1:0]    r_count;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_last_shift;
  logic             w_last_gap;

  assign w_empty      = (r_count == '0);
  assign w_push       = in_valid && in_ready && !rst;
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_last_gap   = (r_state == S_GAP) && (r_cnt == CW'(GAP - 1));
  // Popping in the last GAP cycle keeps back-to-back frames exactly WIDTH+GAP apart.
  assign w_pop        = !rst && !w_empty && ((r_state == S_IDLE) || w_last_gap);

`ifdef SERIAL_OPERAND_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] r_mem_a [FIFO_DEPTH];
  logic [WIDTH-1:0] r_mem_b [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;

  assign in_ready = (r_count != OW'(FIFO_DEPTH));
  assign w_head_a = r_mem_a[r_rptr];
  assign w_head_b = r_mem_b[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [WIDTH-1:0] r_hold_a;
  logic [WIDTH-1:0] r_hold_b;
  logic             w_hold_valid;

  // A push needs an empty register, so push and pop never share an edge here.
  assign w_hold_valid = !w_empty;
  assign in_ready     = !w_hold_valid;
  assign w_head_a     = r_hold_a;
  assign w_head_b     = r_hold_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_a <= '0;
      r_hold_b <= '0;
      r_count  <= '0;
    end else if (w_push) begin
      r_hold_a <= in_a;
      r_hold_b <= in_b;
      r_count  <= OW'(1);
    end else if (w_pop) begin
      r_count  <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
    end else if (w_pop) begin
      r_sh_a <= w_head_a;
      r_sh_b <= w_head_b;
    end else if (r_state == S_SHIFT) begin
      r_sh_a <= r_sh_a << 1;
      r_sh_b <= r_sh_b << 1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ser_en      = 1'b0;
    ser_a       = 1'b0;
    ser_b       = 1'b0;
    busy        = (r_state != S_IDLE);
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        ser_en = (r_cnt == '0);
        ser_a  = r_sh_a[WIDTH-1];
        ser_b  = r_sh_b[WIDTH-1];
        if (w_last_shift) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        frame_done = w_last_gap;
        if (w_last_gap) begin
          w_state_nxt = w_pop ? S_SHIFT : S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - directed self-checking bench for serial_operand_feeder
module tb_serial_operand_feeder;
  localparam int WIDTH      = 2;
  localparam int GAP        = 5;
  localparam int FIFO_DEPTH = 4;
`ifdef SERIAL_OPERAND_FIFO_EN
  localparam int EXP_FULL_ACCEPTS = 5;
`else
  localparam int EXP_FULL_ACCEPTS = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_en;
  logic             ser_a;
  logic             ser_b;
  logic             busy;
  logic             frame_done;
  logic [4:0]       obs;

  int checks   = 0;
  int failures = 0;
  int idx, nacc, nbad, nf, ndone, collect;
  int starts [2];
  logic             acc;
  logic [2:0]       exp3;
  logic [4:0]       exp5;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       sums [2];
  logic [1:0]       pa [3] = '{2'b01, 2'b11, 2'b00};
  logic [1:0]       pb [3] = '{2'b01, 2'b10, 2'b11};

  serial_operand_feeder #(.WIDTH(WIDTH), .GAP(GAP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ser_en(ser_en), .ser_a(ser_a), .ser_b(ser_b),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  assign obs = {ser_en, ser_a, ser_b, busy, frame_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) tick;
    check("reset_outs", obs, 5'b00000);
    rst = 1'b0;
    tick;
    check("reset_ready", in_ready, 1);

    // Single frame a=10 b=11
    in_valid = 1'b1; in_a = 2'b10; in_b = 2'b11;
    check("t1_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("t1_c0", obs, 5'b00000);
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1)      exp5 = 5'b11110;
      else if (c == 2) exp5 = 5'b00110;
      else if (c < 7)  exp5 = 5'b00010;
      else if (c == 7) exp5 = 5'b00011;
      else             exp5 = 5'b00000;
      check($sformatf("t1_c%0d", c), obs, exp5);
    end

    // Back-to-back frames
    idx = 0; in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    for (int c = 0; c <= 22; c++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_a = pa[idx]; in_b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (c >= 1) begin
        exp3 = 3'b000;
        if (((c - 1) / 7) < 3 && ((c - 1) % 7) < WIDTH) begin
          exp3[2] = (((c - 1) % 7) == 0);
          exp3[1] = pa[(c - 1) / 7][WIDTH - 1 - ((c - 1) % 7)];
          exp3[0] = pb[(c - 1) / 7][WIDTH - 1 - ((c - 1) % 7)];
        end
        check($sformatf("t2_c%0d", c), obs[4:2], exp3);
      end
    end

    // Buffer full with in_valid held high
    in_valid = 1'b1; nacc = 0;
    for (int c = 0; c <= 8; c++) begin
      in_a = c[1:0]; in_b = ~c[1:0];
      if (in_ready && c <= 7) nacc++;
      tick;
      if (c == 7) check("t3_ready_c7", in_ready, 0);
      if (c == 8) check("t3_ready_c8", in_ready, 1);
    end
    in_valid = 1'b0;
    check("t3_accepts", nacc, EXP_FULL_ACCEPTS);
    rst = 1'b1; tick; rst = 1'b0; tick;
    check("t3_cleared", obs, 5'b00000);

    // Reset mid-frame
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b11;
    tick;
    in_a = 2'b01; in_b = 2'b10;
    tick;
    check("t4_shift0", obs, 5'b11110);
    tick;
    check("t4_shift1", obs, 5'b01110);
    rst = 1'b1;
    tick;
    check("t4_rst_outs", obs, 5'b00000);
    tick;
    check("t4_rst_hold", obs, 5'b00000);
    rst = 1'b0; in_valid = 1'b0;
    check("t4_ready", in_ready, 1);
    nbad = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ser_en || busy) nbad++;
    end
    check("t4_no_resume", nbad, 0);
    in_valid = 1'b1; in_a = 2'b10; in_b = 2'b01;
    tick;
    in_valid = 1'b0;
    check("t4_lat_k", obs, 5'b00000);
    tick;
    check("t4_lat_k1", obs, 5'b11010);
    repeat (7) tick;
    check("t4_idle", obs, 5'b00000);

    // Operand reconstruction for 3+3 and 2+1
    idx = 0; nf = 0; ndone = 0; collect = 0; ra = '0; rb = '0;
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b11;
    for (int c = 0; c <= 20; c++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx == 1) begin
          in_a = 2'b10; in_b = 2'b01;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (frame_done) ndone++;
      if (ser_en && nf < 2) begin
        starts[nf] = c;
        collect = WIDTH;
      end
      if (collect > 0) begin
        ra = {ra[WIDTH-2:0], ser_a};
        rb = {rb[WIDTH-2:0], ser_b};
        collect--;
        if (collect == 0 && nf < 2) begin
          sums[nf] = {1'b0, ra} + {1'b0, rb};
          nf++;
        end
      end
    end
    check("t5_frames", nf, 2);
    check("t5_done_pulses", ndone, 2);
    if (nf == 2) begin
      check("t5_sum0", sums[0], 3'b110);
      check("t5_sum1", sums[1], 3'b011);
      check("t5_spacing", starts[1] - starts[0], WIDTH + GAP);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
